// File: rtl/lzc_exec_unit_if.sv
// Issue/result handshake bundle for the count-leading-zeros/ones execution unit.
// master = reservation station + writeback side, slave = the unit.
interface lzc_exec_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 4
);
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_op;
  logic [DATA_WIDTH-1:0] in_data;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic [CNT_W-1:0]      out_cnt;
  logic                  out_full;

  modport master (
    output in_valid, in_op, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_tag, out_cnt, out_full
  );

  modport slave (
    input  in_valid, in_op, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_tag, out_cnt, out_full
  );
endinterface

// File: rtl/lzc_exec_unit.sv
// Two-stage CLZ/CLO execution unit (S1 operand conditioning, S2 count/result).
// Define LZC_UNIT_CTZ_EN to add trailing-count ops (CTZ/CTO) via operand bit reversal.
module leading_zero_one_cnt #(
  parameter int WIDTH      = 16,
  parameter bit COUNT_ZERO = 1'b1
) (
  input  logic [WIDTH-1:0]       data_i,
  output logic [$clog2(WIDTH):0] cnt_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  // Scanning upward lets the highest terminating bit win.
  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (data_i[i] == COUNT_ZERO) cnt_o = CW'(WIDTH - 1 - i);
  end
endmodule

module lzc_exec_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  lzc_exec_unit_if.slave   io
);
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s1_opnd_q, s1_opnd_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;
  logic [TAG_WIDTH-1:0]  s2_tag_q, s2_tag_d;
  logic [CNT_W-1:0]      s2_cnt_q, s2_cnt_d;
  logic [CNT_W-1:0]      cnt_c;
  logic [DATA_WIDTH-1:0] opnd_base, opnd_cond;
  logic                  s2_free, s1_adv, accept;

`ifdef LZC_UNIT_CTZ_EN
  logic [DATA_WIDTH-1:0] opnd_rev;

  always_comb begin
    opnd_rev = '0;
    for (int i = 0; i < DATA_WIDTH; i++) opnd_rev[i] = io.in_data[DATA_WIDTH-1-i];
  end
  assign opnd_base = io.in_op[1] ? opnd_rev : io.in_data;
`else
  logic unused_op_hi;

  assign unused_op_hi = io.in_op[1];
  assign opnd_base    = io.in_data;
`endif

  // Inversion after reversal turns ones-counting into zero-counting.
  assign opnd_cond = io.in_op[0] ? ~opnd_base : opnd_base;

  leading_zero_one_cnt #(.WIDTH(DATA_WIDTH), .COUNT_ZERO(1'b1)) u_cnt (
    .data_i (s1_opnd_q),
    .cnt_o  (cnt_c)
  );

  assign s2_free     = !s2_valid_q || io.out_ready;
  assign s1_adv      = s1_valid_q && s2_free;
  assign io.in_ready = !s1_valid_q || s2_free;
  assign accept      = io.in_valid && io.in_ready && !flush_i;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_opnd_d  = s1_opnd_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_tag_d   = s2_tag_q;
    s2_cnt_d   = s2_cnt_q;
    if (s1_adv) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b1;
      s2_tag_d   = s1_tag_q;
      s2_cnt_d   = cnt_c;
    end else if (io.out_ready) begin
      s2_valid_d = 1'b0;
    end
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_opnd_d  = opnd_cond;
      s1_tag_d   = io.in_tag;
    end
    // Flush only kills the valids; stale data is harmless behind them.
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_opnd_q  <= '0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      s2_cnt_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_opnd_q  <= s1_opnd_d;
      s1_tag_q   <= s1_tag_d;
      s2_tag_q   <= s2_tag_d;
      s2_cnt_q   <= s2_cnt_d;
    end
  end

  assign io.out_valid = s2_valid_q;
  assign io.out_tag   = s2_tag_q;
  assign io.out_cnt   = s2_cnt_q;
  assign io.out_full  = s2_cnt_q[CNT_W-1];
endmodule

// File: tb/tb_lzc_exec_unit.sv
// Bench for lzc_exec_unit: directed plan steps then random traffic against a queue model.
// Trailing-op expectations follow LZC_UNIT_CTZ_EN as seen by this compile.
module tb_lzc_exec_unit;
  localparam int DW = 16;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst, flush;
  int   edges = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    logic [TW-1:0] tag;
    int            cnt;
    int            acc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  lzc_exec_unit_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  lzc_exec_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .io      (bus.slave)
  );

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Counts the run of bits equal to op[0] from the chosen end of the operand.
  function automatic int ref_cnt(input logic [1:0] op, input logic [DW-1:0] d);
    int n = 0;
    bit done = 0;
    bit trail;
`ifdef LZC_UNIT_CTZ_EN
    trail = op[1];
`else
    trail = 1'b0;
`endif
    for (int k = 0; k < DW; k++) begin
      int b;
      b = trail ? k : DW - 1 - k;
      if (!done && d[b] == op[0]) n++;
      else done = 1;
    end
    return n;
  endfunction

  // One clock: drive after the edge, check at negedge, then advance the model.
  task automatic cyc(input logic v, input logic [1:0] op, input logic [DW-1:0] d,
                     input logic [TW-1:0] tg, input logic ordy, input logic fl);
    bit vis, rdy;
    @(posedge clk); #1;
    bus.in_valid = v; bus.in_op = op; bus.in_data = d; bus.in_tag = tg;
    bus.out_ready = ordy; flush = fl;
    @(negedge clk);
    vis = (q.size() > 0) && (edges >= q[0].acc + 1);
    rdy = (q.size() < 2) || ordy;
    chk("out_valid", 32'(bus.out_valid), 32'(vis));
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    if (vis) begin
      chk("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
      chk("out_cnt", 32'(bus.out_cnt), 32'(q[0].cnt));
      chk("out_full", 32'(bus.out_full), 32'(q[0].cnt == DW));
    end
    if (vis && ordy) void'(q.pop_front());
    if (fl) q.delete();
    if (v && rdy && !fl) q.push_back('{tag: tg, cnt: ref_cnt(op, d), acc: edges + 1});
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 2'b00, '0, '0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; bus.in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    q.delete();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
    chk("rst_out_full", 32'(bus.out_full), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_data = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Plan 1: latency and basic CLZ.
    cyc(1'b1, 2'b00, 16'h0010, 4'd3, 1'b1, 1'b0);
    idle(1'b1);
    chk("p1_no_early_valid", 32'(bus.out_valid), 32'd0);
    idle(1'b1);
    chk("p1_tag", 32'(bus.out_tag), 32'd3);
    chk("p1_cnt", 32'(bus.out_cnt), 32'd11);

    // Plan 2: back-to-back mix.
    cyc(1'b1, 2'b01, 16'hFF00, 4'd4, 1'b1, 1'b0);
    cyc(1'b1, 2'b00, 16'h0000, 4'd5, 1'b1, 1'b0);
    cyc(1'b1, 2'b00, 16'h8000, 4'd6, 1'b1, 1'b0);
    chk("p2_clo_cnt", 32'(bus.out_cnt), 32'd8);
    idle(1'b1);
    chk("p2_zero_cnt", 32'(bus.out_cnt), 32'd16);
    chk("p2_zero_full", 32'(bus.out_full), 32'd1);
    idle(1'b1);
    chk("p2_msb_cnt", 32'(bus.out_cnt), 32'd0);
    idle(1'b1);

    // Plan 3: backpressure, two buffered, third stalled.
    cyc(1'b1, 2'b00, 16'h0001, 4'd1, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 16'h0002, 4'd2, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 16'h0004, 4'd3, 1'b0, 1'b0);
    chk("p3_in_ready_low", 32'(bus.in_ready), 32'd0);
    cyc(1'b1, 2'b00, 16'h0004, 4'd3, 1'b0, 1'b0);
    chk("p3_hold_tag", 32'(bus.out_tag), 32'd1);
    cyc(1'b1, 2'b00, 16'h0004, 4'd3, 1'b1, 1'b0);
    chk("p3_emerge1", 32'(bus.out_tag), 32'd1);
    idle(1'b1);
    chk("p3_emerge2", 32'(bus.out_tag), 32'd2);
    idle(1'b1);
    chk("p3_emerge3", 32'(bus.out_tag), 32'd3);
    idle(1'b1);

    // Plan 4: flush with a presented op.
    cyc(1'b1, 2'b00, 16'h0100, 4'd7, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 16'h0200, 4'd8, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 16'h0400, 4'd9, 1'b0, 1'b1);
    idle(1'b1);
    chk("p4_flushed", 32'(bus.out_valid), 32'd0);
    cyc(1'b1, 2'b00, 16'h0040, 4'd10, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("p4_after_flush_cnt", 32'(bus.out_cnt), 32'd9);
    chk("p4_after_flush_tag", 32'(bus.out_tag), 32'd10);

    // Plan 5: reset with both stages full and stalled.
    cyc(1'b1, 2'b01, 16'hF000, 4'd11, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 16'hFF00, 4'd12, 1'b0, 1'b0);
    idle(1'b0);
    do_reset();
    idle(1'b1);
    idle(1'b1);

    // Plan 6: trailing ops, or their leading aliases.
    cyc(1'b1, 2'b10, 16'h0008, 4'd1, 1'b1, 1'b0);
    cyc(1'b1, 2'b11, 16'h00FF, 4'd2, 1'b1, 1'b0);
    cyc(1'b1, 2'b10, 16'h0000, 4'd3, 1'b1, 1'b0);
`ifdef LZC_UNIT_CTZ_EN
    chk("p6_ctz", 32'(bus.out_cnt), 32'd3);
    idle(1'b1);
    chk("p6_cto", 32'(bus.out_cnt), 32'd8);
`else
    chk("p6_op10_as_clz", 32'(bus.out_cnt), 32'd12);
    idle(1'b1);
    chk("p6_op11_as_clo", 32'(bus.out_cnt), 32'd0);
`endif
    idle(1'b1);
    chk("p6_zero_cnt", 32'(bus.out_cnt), 32'd16);
    chk("p6_zero_full", 32'(bus.out_full), 32'd1);
    idle(1'b1);

    // Random traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom) >> $urandom_range(0, DW);
      if ($urandom_range(0, 1) == 1) d = ~d;
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), d, TW'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end
    repeat (4) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lzc_exec_unit.md
Name: lzc_exec_unit

Overview:
- Pipelined count-leading-zeros/ones execution unit for the OOO core.
- Accepts issued ops from the reservation station through a valid/ready handshake.
- Computes the count with a leading_zero_one_cnt instance (COUNT_ZERO=1) on a conditioned operand.
- Returns tagged results to the writeback/CDB arbiter through a second valid/ready handshake. Supports pipeline flush on branch mispredict.

Parameters:
- DATA_WIDTH, 16, operand width; power of two, minimum 2.
- TAG_WIDTH, 4, width of the ROB/physical-register tag carried with each op.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill all in-flight ops; synchronous.
- in_valid  input  1  issue request valid.
- in_ready  output  1  unit can accept an op this cycle.
- in_op  input  2  00 CLZ, 01 CLO, 10 CTZ, 11 CTO. Codes 1x require LZC_UNIT_CTZ_EN.
- in_data  input  DATA_WIDTH  source operand.
- in_tag  input  TAG_WIDTH  destination tag.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts the result.
- out_tag  output  TAG_WIDTH  tag of the result.
- out_cnt  output  $clog2(DATA_WIDTH)+1  count; equals DATA_WIDTH when no terminating bit is present.
- out_full  output  1  operand was uniform: all 0 for CLZ/CTZ, all 1 for CLO/CTO. Equals out_cnt[MSB].

Behaviour:
- **Reset:** two pipeline stages S1 (operand conditioning) and S2 (count/result). On rst: s1_valid=0, s2_valid=0, out_valid=0, out_tag=0, out_cnt=0, out_full=0. in_ready=1 in the first cycle after reset.
- **Acceptance:** an op is accepted on a cycle with in_valid && in_ready && !flush.
- **S1 load:** on accept, S1 captures the conditioned operand and the tag.
  - Conditioned operand = in_data for CLZ, ~in_data for CLO.
  - With the feature: bit-reversed in_data for CTZ, bit-reversed ~in_data for CTO.
- **S2 load:** the combinational leading-zero count of the S1 operand is registered into out_cnt/out_full, and the tag into out_tag.
- **Latency:** 2 cycles from accept to out_valid when unstalled. Throughput is 1 op/cycle.
- **Advance rules:**
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free (combinational; no dependence on in_valid).
- **Stall:** with out_ready low, S2 holds out_tag/out_cnt/out_full stable while out_valid=1. S1 holds its contents. At most 2 ops are buffered; in_ready drops once both stages are occupied.
- **Simultaneous accept and advance:** in the same cycle, S1 takes the new op and S2 takes the old S1 op.
- **Result consumption:** out_valid && out_ready pops S2. If S1 is valid, S2 refills in that same cycle, so there are no bubbles.
- **Ordering:** results leave in accept order.
- **Flush:** s1_valid and s2_valid clear at the next edge.
  - An op presented during flush is dropped and not accepted, even though in_ready may be high.
  - A result handshaken in the same cycle as flush counts as delivered.
  - Data registers need not clear.
- **flush and rst together:** rst wins; the effect is identical either way.
- **Reset mid-operation:** all in-flight ops are dropped; no out_valid pulse follows.
- **Width rules:** out_cnt ranges over 0..DATA_WIDTH. The MSB is set only for DATA_WIDTH.

Optional Feature:
- **Macro:** LZC_UNIT_CTZ_EN.
- **Defined:** in_op[1] selects trailing mode. The operand is bit-reversed in S1 before optional inversion, giving CTZ (op 10) and CTO (op 11) through the same counter.
- **Undefined:** in_op[1] is ignored; ops 10/11 execute as CLZ/CLO respectively. The reversal mux is not synthesised.

Test Plan:
1. DATA_WIDTH=16, out_ready=1. CLZ 16'h0010 tag 3 accepted at cycle t -> out_valid at t+2, out_tag=3, out_cnt=11, out_full=0.
2. CLO 16'hFF00 -> out_cnt=8. CLZ 16'h0000 -> out_cnt=16, out_full=1. CLZ 16'h8000 -> out_cnt=0. All issued back-to-back; results arrive on consecutive cycles in order.
3. Issue tags 1,2,3 back-to-back with out_ready=0 -> in_ready=0 after tags 1,2 are held, and tag 3 is stalled. out_tag stays 1 while stalled. Raise out_ready -> tags 1,2,3 emerge on 3 consecutive cycles.
4. Two ops in flight, assert flush for 1 cycle while in_valid=1 -> out_valid=0 from the next cycle, flushed and presented op never appears. An op issued after flush returns the correct count 2 cycles later.
5. Assert rst with S1 and S2 full and out_ready=0 -> all outputs 0 next cycle, in_ready=1, no stale result later.
6. With LZC_UNIT_CTZ_EN: CTZ 16'h0008 -> 3, CTO 16'h00FF -> 8, CTZ 0 -> 16/out_full=1. Without it: op 10 on 16'h0008 -> 12.
